// File: rtl/gate_reduce_pkg.sv
// Shared types for the N-ary gate reducer.
//   op_mode_e : operation select encoding as seen on op_mode
//   state_e   : reducer FSM states, also exported on the debug state port
package gate_reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/nary_gate_reducer_if.sv
// Operand/result streams of the N-ary gate reducer.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and its payload stable until the transfer; ready may
// change freely and never depends combinationally on valid.
//   op_mode   : operation select, qualified by the first operand beat
//   in_valid  : operand present on in_data
//   in_ready  : reducer can accept an operand
//   in_data   : operand
//   out_valid : result present on out_data
//   out_ready : downstream accepts the result
//   out_data  : reduction result
// slave  : reducer side, master : producer/consumer side
interface nary_gate_reducer_if #(parameter int WIDTH = 1) ();
  logic [1:0]       op_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  op_mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output op_mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/nary_gate_reducer_gate2_cell.sv
// gate2_cell: combinational 2-input bitwise gate, WIDTH bits wide.
//   i_a, i_b : operands
//   i_mode   : operation; NAND evaluates as AND (the caller inverts the
//              final result, so intermediate steps stay plain AND)
//   o_y      : i_a OP i_b
module gate2_cell
  import gate_reduce_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_mode_e         i_mode,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_a & i_b;
    case (i_mode)
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = i_a & i_b;
    endcase
  end

endmodule

// File: rtl/nary_gate_reducer.sv
// nary_gate_reducer: folds N_OPS serially arriving operands with a bitwise
// AND/OR/XOR/NAND and emits one result per reduction.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : operand/result streams (slave side)
//   o_state : current FSM state for observation
module nary_gate_reducer
  import gate_reduce_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N_OPS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  nary_gate_reducer_if.slave       bus,
  output state_e                   o_state
);

  localparam int CNT_W = $clog2(N_OPS + 1);

  generate
    if (N_OPS < 2) begin : g_bad_n_ops
      $error("nary_gate_reducer: N_OPS must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("nary_gate_reducer: WIDTH must be >= 1");
    end
  endgenerate

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  op_mode_e         r_mode, w_mode_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_out_data, w_out_data_nxt;

  logic             w_in_ready;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_gate_y;

  // No operand is taken while a result waits, so a held result can never
  // be disturbed and a new reduction starts only from IDLE.
  assign w_in_ready = (r_state != HOLD);
  assign w_in_fire  = bus.in_valid && w_in_ready;

  // Single fold cell: running accumulator OP incoming operand.
  gate2_cell #(.WIDTH(WIDTH)) u_gate (
    .i_a    (r_acc),
    .i_b    (bus.in_data),
    .i_mode (r_mode),
    .o_y    (w_gate_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mode      <= OP_AND;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mode      <= w_mode_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_mode_nxt      = r_mode;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    case (r_state)
      IDLE: begin
        if (w_in_fire) begin
          w_acc_nxt   = bus.in_data;
          w_mode_nxt  = op_mode_e'(bus.op_mode);
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_in_fire) begin
          w_acc_nxt = w_gate_y;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          // This beat is the last one of the reduction.
          if (r_cnt == CNT_W'(N_OPS - 1)) begin
            w_out_data_nxt  = (r_mode == OP_NAND) ? ~w_gate_y : w_gate_y;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_state       = r_state;

endmodule

// File: tb/tb_nary_gate_reducer.sv
// Directed bench for nary_gate_reducer: three instances cover WIDTH=4/N=3,
// WIDTH=1/N=3 and WIDTH=8/N=5. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_nary_gate_reducer;
  import gate_reduce_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  state_e st_a, st_b, st_c;

  nary_gate_reducer_if #(.WIDTH(4)) if_a ();
  nary_gate_reducer_if #(.WIDTH(1)) if_b ();
  nary_gate_reducer_if #(.WIDTH(8)) if_c ();

  nary_gate_reducer #(.WIDTH(4), .N_OPS(3)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .o_state(st_a));
  nary_gate_reducer #(.WIDTH(1), .N_OPS(3)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .o_state(st_b));
  nary_gate_reducer #(.WIDTH(8), .N_OPS(5)) u_dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave), .o_state(st_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: entered and left on a falling edge, in_valid low on exit
  task automatic a_beat(input logic [3:0] d, input logic [1:0] m);
    int t = 0;
    if_a.in_valid = 1'b1; if_a.in_data = d; if_a.op_mode = m;
    while (!if_a.in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check("a_beat_timeout", 0, 1);
    @(negedge clk);
    if_a.in_valid = 1'b0;
  endtask

  task automatic b_beat(input logic d, input logic [1:0] m);
    int t = 0;
    if_b.in_valid = 1'b1; if_b.in_data = d; if_b.op_mode = m;
    while (!if_b.in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check("b_beat_timeout", 0, 1);
    @(negedge clk);
    if_b.in_valid = 1'b0;
  endtask

  task automatic c_beat(input logic [7:0] d, input logic [1:0] m);
    int t = 0;
    if_c.in_valid = 1'b1; if_c.in_data = d; if_c.op_mode = m;
    while (!if_c.in_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) check("c_beat_timeout", 0, 1);
    @(negedge clk);
    if_c.in_valid = 1'b0;
  endtask

  logic [7:0] xor_beats [5];
  logic [1:0] m;
  logic [2:0] vb;
  logic       exp_b;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    xor_beats[0] = 8'h01; xor_beats[1] = 8'h02; xor_beats[2] = 8'h04;
    xor_beats[3] = 8'h08; xor_beats[4] = 8'h10;
    if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.op_mode = OP_AND; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.op_mode = OP_AND; if_b.out_ready = 1'b1;
    if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.op_mode = OP_AND; if_c.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_a_state",     32'(st_a), 32'(IDLE));
    check("rst_a_out_valid", 32'(if_a.out_valid), 0);
    check("rst_a_out_data",  32'(if_a.out_data), 0);
    check("rst_a_in_ready",  32'(if_a.in_ready), 1);
    check("rst_c_out_valid", 32'(if_c.out_valid), 0);
    check("rst_c_in_ready",  32'(if_c.in_ready), 1);

    // AND F,C,6 back-to-back -> 4
    a_beat(4'hF, OP_AND);
    a_beat(4'hC, OP_AND);
    check("and_beat2_no_valid", 32'(if_a.out_valid), 0);
    a_beat(4'h6, OP_AND);
    check("and_valid",     32'(if_a.out_valid), 1);
    check("and_data",      32'(if_a.out_data), 32'h4);
    check("and_hold",      32'(st_a), 32'(HOLD));
    @(negedge clk);
    check("and_back_idle", 32'(st_a), 32'(IDLE));
    check("and_valid_clr", 32'(if_a.out_valid), 0);

    // WIDTH=1 exhaustive OR and NAND truth tables
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 2; k++) begin
        vb = 3'(v);
        m  = (k == 1) ? OP_NAND : OP_OR;
        exp_b = (k == 1) ? (vb != 3'b111) : (vb != 3'b000);
        b_beat(vb[2], m);
        b_beat(vb[1], m);
        b_beat(vb[0], m);
        check((k == 1) ? "nand_valid" : "or_valid", 32'(if_b.out_valid), 1);
        check((k == 1) ? "nand_data" : "or_data", 32'(if_b.out_data), 32'(exp_b));
        @(negedge clk);
      end
    end

    // XOR with gaps, result held under backpressure
    if_c.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c_beat(xor_beats[i], OP_XOR);
      if (i < 4) begin
        repeat (2) begin
          @(negedge clk);
          check("xor_gap_state", 32'(st_c), 32'(ACCUM));
          check("xor_gap_valid", 32'(if_c.out_valid), 0);
        end
      end
    end
    // offer a beat while the result is held
    if_c.in_valid = 1'b1; if_c.in_data = 8'hAA; if_c.op_mode = OP_AND;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid",    32'(if_c.out_valid), 1);
      check("bp_data",     32'(if_c.out_data), 32'h1F);
      check("bp_in_ready", 32'(if_c.in_ready), 0);
      @(negedge clk);
    end
    if_c.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_state", 32'(st_c), 32'(IDLE));
    check("bp_release_valid", 32'(if_c.out_valid), 0);
    check("bp_release_ready", 32'(if_c.in_ready), 1);
    @(negedge clk);
    if_c.in_valid = 1'b0;
    check("held_beat_taken_in_idle", 32'(st_c), 32'(ACCUM));
    c_beat(8'hFF, OP_OR);
    c_beat(8'hFF, OP_OR);
    c_beat(8'hFF, OP_OR);
    check("held_beat_once", 32'(if_c.out_valid), 0);
    c_beat(8'h0F, OP_OR);
    check("held_beat_valid", 32'(if_c.out_valid), 1);
    check("held_beat_data",  32'(if_c.out_data), 32'h0A);
    @(negedge clk);

    // mode change after first beat is ignored: OR 1,2,4 -> 7
    a_beat(4'h1, OP_OR);
    a_beat(4'h2, OP_AND);
    a_beat(4'h4, OP_AND);
    check("mode_keep_valid", 32'(if_a.out_valid), 1);
    check("mode_keep_data",  32'(if_a.out_data), 32'h7);
    @(negedge clk);

    // reset mid-reduction discards the partial result
    a_beat(4'h0, OP_AND);
    a_beat(4'h0, OP_AND);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(if_a.out_valid), 0);
    check("midrst_ready", 32'(if_a.in_ready), 1);
    check("midrst_state", 32'(st_a), 32'(IDLE));
    a_beat(4'hF, OP_AND);
    a_beat(4'hF, OP_AND);
    check("fresh_no_early_valid", 32'(if_a.out_valid), 0);
    a_beat(4'h3, OP_AND);
    check("fresh_valid", 32'(if_a.out_valid), 1);
    check("fresh_data",  32'(if_a.out_data), 32'h3);
    @(negedge clk);
    check("fresh_done", 32'(if_a.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nary_gate_reducer.md
Name: nary_gate_reducer

Overview:
- Parametrised successor to the fixed 3-input AND/OR gates: reduces N_OPS operands of WIDTH bits with a selectable bitwise operation (AND/OR/XOR/NAND).
- Operands arrive serially on a valid/ready stream; one result is emitted per reduction on an output valid/ready stream.
- Sits between operand producers and downstream logic in the lab datapath. It replaces chained 2-input gate instances when operand count or width varies.

Parameters:
- WIDTH, 1, bit width of each operand and of the result; must be >= 1.
- N_OPS, 3, operands per reduction; must be >= 2. Elaboration fails via $error if N_OPS < 2 or WIDTH < 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_mode  in  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND. Sampled only on the first beat of a reduction.
- in_valid  in  1  operand present on in_data.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result present on out_data.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  reduction result.

Behaviour:
- Reset: all outputs and state are cleared. state=IDLE, acc=0, cnt=0, mode_q=AND, out_valid=0, out_data=0, in_ready=1 on the first cycle after reset.
- Beat acceptance: a beat is accepted when in_valid && in_ready on a clock edge. out_data is accepted when out_valid && out_ready on a clock edge.
- States and transitions:
  - IDLE: in_ready=1. On an accepted beat: acc<=in_data, mode_q<=op_mode, cnt<=1, go to ACCUM.
  - ACCUM: in_ready=1. On an accepted beat: acc<=acc OP in_data, cnt<=cnt+1. OP is AND for both AND and NAND modes.
  - ACCUM, final beat: when the accepted beat makes cnt reach N_OPS, register out_data. out_data = ~(acc & in_data) for NAND; otherwise acc OP in_data. Then out_valid<=1 and go to HOLD.
  - HOLD: in_ready=0 and out_data is stable. On an accepted result: out_valid<=0, cnt<=0, go to IDLE.
- No beat is accepted in HOLD. There is no same-cycle bypass from HOLD to a new reduction.
- Cycles with in_valid=0 in IDLE or ACCUM hold all state unchanged; gaps are allowed.
- op_mode changes after the first beat are ignored until the next reduction.
- Latency: out_valid rises on the edge that accepts beat N_OPS. Minimum period is N_OPS+1 cycles per result.
- cnt width is $clog2(N_OPS+1). cnt never exceeds N_OPS.
- Reset mid-reduction or in HOLD discards the partial or held result. No spurious out_valid follows reset.
- out_valid, once high, stays high with stable out_data until it is accepted (AXI-style; must not drop).
- XOR across N_OPS operands gives per-bit odd parity.

Decomposition:
- gate_reduce_pkg:
  - typedef enum logic [1:0] op_mode_e {OP_AND, OP_OR, OP_XOR, OP_NAND}.
  - typedef enum state_e {IDLE, ACCUM, HOLD}.
- Sub-module gate2_cell (combinational, parametrised WIDTH): inputs a, b, mode; output y = a OP b, with NAND handled as AND. It generalises the existing 2-input andgate/orgate.
- The reducer instantiates one gate2_cell and applies the final NAND inversion itself.

Test Plan:
- WIDTH=4, N_OPS=3, AND, beats 4'hF, 4'hC, 4'h6 back-to-back, out_ready=1 -> out_valid on the 3rd accept edge, out_data=4'h4, then IDLE.
- WIDTH=1, N_OPS=3, OR and NAND over all 8 input combinations (exhaustive, matching the 3-input gate truth tables) -> OR=0 only for 000; NAND=0 only for 111.
- WIDTH=8, N_OPS=5, XOR, beats 8'h01, 02, 04, 08, 10 with idle gaps -> out_data=8'h1F. Gaps leave cnt and acc unchanged.
- Backpressure: out_ready=0 for 4 cycles after the result -> out_valid held, out_data stable, in_ready=0. A beat offered in HOLD is not accepted; it is accepted first in IDLE after the handshake.
- Mode change: first beat with OR, op_mode switched to AND on beat 2, beats 4'h1, 4'h2, 4'h4 -> out_data=4'h7 (OR retained).
- rst pulsed after 2 of 3 beats -> out_valid=0, in_ready=1. A fresh AND reduction of 4'hF, 4'hF, 4'h3 -> 4'h3 with no stale contribution.
